// File: rtl/load_aligner_if.sv
// Handshake and bus bundle for load_aligner: core request, data-memory read and core response.
interface load_aligner_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;

    modport slave (
        input  req_valid, req_addr, req_funct3, mem_ack, mem_rdata, rsp_ready,
        output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_funct3, mem_ack, mem_rdata, rsp_ready,
        input  req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/extend.sv
// Sign/zero extension of an IN_W-bit value to 32 bits; uext=1 selects zero extension.
module extend #(
    parameter int unsigned IN_W = 8
) (
    input  logic [IN_W-1:0] din,
    input  logic            uext,
    output logic [31:0]     dout
);
    assign dout = {{(32 - IN_W){~uext & din[IN_W-1]}}, din};
endmodule

// File: rtl/load_aligner.sv
// RISC-V load aligner: one word read per load, byte/halfword extraction and extension,
// misaligned / illegal-funct3 / bus-timeout reporting through rsp_err.
module load_aligner #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    load_aligner_if.slave  bus
);
    localparam int unsigned CNT_W = 16;
    localparam logic [1:0]  ERR_OK       = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0]  ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    state_e           state_q, state_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_err_q, rsp_err_d;

    logic             illegal_c, misaligned_c;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      byte_ext, half_ext, load_word;
    logic [CNT_W-1:0] cnt_inc;

    // Classify the incoming request; only the five RISC-V load codes are legal.
    always_comb begin
        illegal_c    = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned_c = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end

    // Lane selection from the little-endian read word.
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = bus.mem_rdata[7:0];
            2'd1:    byte_sel = bus.mem_rdata[15:8];
            2'd2:    byte_sel = bus.mem_rdata[23:16];
            default: byte_sel = bus.mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    end

    extend #(.IN_W(8))  u_ext8  (.din(byte_sel), .uext(f3_q[2]), .dout(byte_ext));
    extend #(.IN_W(16)) u_ext16 (.din(half_sel), .uext(f3_q[2]), .dout(half_ext));

    always_comb begin
        case (f3_q[1:0])
            2'b00:   load_word = byte_ext;
            2'b01:   load_word = half_ext;
            default: load_word = bus.mem_rdata;
        endcase
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        f3_d       = f3_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    off_d = bus.req_addr[1:0];
                    f3_d  = bus.req_funct3;
                    cnt_d = '0;
                    if (illegal_c) begin
                        state_d    = RESP;
                        rsp_err_d  = ERR_ILLEGAL;
                        rsp_data_d = '0;
                    end else if (misaligned_c) begin
                        state_d    = RESP;
                        rsp_err_d  = ERR_MISALIGN;
                        rsp_data_d = '0;
                    end else begin
                        state_d    = BUS;
                        mem_addr_d = {bus.req_addr[31:2], 2'b00};
                    end
                end
            end
            BUS: begin
                // An ack arriving in the expiry cycle still completes the load.
                if (bus.mem_ack) begin
                    state_d    = RESP;
                    rsp_data_d = load_word;
                    rsp_err_d  = ERR_OK;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = ERR_TIMEOUT;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        mem_req_d   = (state_d == BUS);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            off_q       <= '0;
            f3_q        <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_load_aligner.sv
// Randomized bench for load_aligner: a transaction-level reference model predicts each
// response, bus-cycle count and latency; a negedge monitor checks the DUT every cycle.
module tb_load_aligner;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_aligner_if bus_if ();
    load_aligner #(.TIMEOUT(TO)) dut (.clk(clk), .reset(rst), .bus(bus_if));

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        int          ack_delay;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        int          exp_bus;
        logic [31:0] exp_maddr;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    bit    stray_hi = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what a load must return, straight from the ISA rules.
    function automatic item_t model(input logic [31:0] addr, input logic [2:0] f3,
                                    input int ack_delay, input logic [31:0] rdata);
        item_t it;
        logic [1:0] off;
        int b, h;
        off = addr[1:0];
        b = int'((rdata >> (8 * off)) & 32'hFF);
        h = int'((rdata >> (16 * off[1])) & 32'hFFFF);
        it.addr = addr; it.f3 = f3; it.ack_delay = ack_delay; it.rdata = rdata;
        it.exp_maddr = addr & 32'hFFFF_FFFC;
        it.exp_data = 32'h0;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
            it.exp_err = 2'b11; it.exp_bus = 0;
        end else if (((f3 == 3'b001 || f3 == 3'b101) && addr[0]) ||
                     (f3 == 3'b010 && addr[1:0] != 2'b00)) begin
            it.exp_err = 2'b01; it.exp_bus = 0;
        end else if (ack_delay >= int'(TO)) begin
            it.exp_err = 2'b10; it.exp_bus = int'(TO);
        end else begin
            it.exp_err = 2'b00; it.exp_bus = ack_delay + 1;
            case (f3)
                3'b000:  it.exp_data = 32'((b >= 128) ? b - 256 : b);
                3'b100:  it.exp_data = 32'(b);
                3'b001:  it.exp_data = 32'((h >= 32768) ? h - 65536 : h);
                3'b101:  it.exp_data = 32'(h);
                default: it.exp_data = rdata;
            endcase
        end
        return it;
    endfunction

    // Memory responder: acks the current load after its wait count, stray acks otherwise.
    int k = 0;
    always @(posedge clk) begin
        #1;
        if (bus_if.mem_req && !rst) begin
            if (q.size() > 0 && k == q[0].ack_delay) begin
                bus_if.mem_ack = 1'b1; bus_if.mem_rdata = q[0].rdata;
            end else begin
                bus_if.mem_ack = 1'b0; bus_if.mem_rdata = $urandom;
            end
            k++;
        end else begin
            k = 0;
            bus_if.mem_ack = stray_hi ? 1'b1 : ($urandom_range(3) == 0);
            bus_if.mem_rdata = $urandom;
        end
    end

    // Cycle monitor.
    int          acc_cyc = 0;
    int          busn = 0;
    bit          in_rsp = 1'b0;
    bit          chk_idle = 1'b0;
    logic [31:0] sd;
    logic [1:0]  se;
    always @(negedge clk) begin
        if (rst) begin
            in_rsp = 1'b0; busn = 0; chk_idle = 1'b0;
        end else begin
            chk("state_onehot", 32'(bus_if.req_ready) + 32'(bus_if.mem_req) + 32'(bus_if.rsp_valid), 32'd1);
            if (chk_idle) begin
                chk("idle_after_rsp", 32'(bus_if.req_ready), 32'd1);
                chk_idle = 1'b0;
            end
            if (bus_if.req_valid && bus_if.req_ready) begin
                acc_cyc = cyc; busn = 0;
            end
            if (bus_if.mem_req) begin
                busn++;
                if (q.size() > 0) chk("mem_addr", bus_if.mem_addr, q[0].exp_maddr);
                else chk("mem_req_without_load", 32'(bus_if.mem_req), 32'd0);
            end
            if (bus_if.rsp_valid) begin
                if (!in_rsp) begin
                    if (q.size() == 0) begin
                        chk("spurious_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
                    end else begin
                        chk("rsp_data", bus_if.rsp_data, q[0].exp_data);
                        chk("rsp_err", 32'(bus_if.rsp_err), 32'(q[0].exp_err));
                        chk("mem_req_cycles", 32'(busn), 32'(q[0].exp_bus));
                        chk("rsp_latency", 32'(cyc - acc_cyc), 32'(q[0].exp_bus + 1));
                        sd = bus_if.rsp_data; se = bus_if.rsp_err; in_rsp = 1'b1;
                    end
                end else begin
                    chk("rsp_data_stable", bus_if.rsp_data, sd);
                    chk("rsp_err_stable", 32'(bus_if.rsp_err), 32'(se));
                end
                if (bus_if.rsp_ready && in_rsp) begin
                    void'(q.pop_front());
                    in_rsp = 1'b0; chk_idle = 1'b1;
                end
            end
        end
    end

    // Issue one load, wait for its response, hold rsp_ready low for 'hold' cycles.
    task automatic do_load(input item_t it, input int hold);
        int n;
        q.push_back(it);
        bus_if.req_addr = it.addr; bus_if.req_funct3 = it.f3;
        bus_if.req_valid = 1'b1; bus_if.rsp_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_if.req_ready && n < 50);
        chk("req_accept_wait", 32'(bus_if.req_ready), 32'd1);
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        n = 0;
        while (!bus_if.rsp_valid && n < 50) begin
            bus_if.req_valid = 1'($urandom_range(1));
            bus_if.req_addr = $urandom; bus_if.req_funct3 = 3'($urandom);
            @(posedge clk); #1; n++;
        end
        chk("rsp_valid_wait", 32'(bus_if.rsp_valid), 32'd1);
        repeat (hold) begin
            bus_if.req_valid = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        bus_if.req_valid = 1'b0; bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;
    endtask

    item_t it;
    logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        bus_if.req_valid = 1'b0; bus_if.req_addr = '0; bus_if.req_funct3 = '0;
        bus_if.rsp_ready = 1'b0; bus_if.mem_ack = 1'b0; bus_if.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(bus_if.req_ready), 32'd1);
        chk("reset_mem_req", 32'(bus_if.mem_req), 32'd0);
        chk("reset_mem_addr", bus_if.mem_addr, 32'd0);
        chk("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("reset_rsp_data", bus_if.rsp_data, 32'd0);
        chk("reset_rsp_err", 32'(bus_if.rsp_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        it = model(32'h103, 3'b000, 0, 32'h8012_3456);
        chk("model_lb", it.exp_data, 32'hFFFF_FF80);
        chk("model_lb_maddr", it.exp_maddr, 32'h100);
        do_load(it, 0);

        it = model(32'h102, 3'b101, 3, 32'h8F00_1234);
        chk("model_lhu", it.exp_data, 32'h0000_8F00);
        do_load(it, 1);
        it = model(32'h102, 3'b001, 3, 32'h8F00_1234);
        chk("model_lh", it.exp_data, 32'hFFFF_8F00);
        do_load(it, 0);

        it = model(32'h101, 3'b010, 0, 32'h1234_5678);
        chk("model_lw_misalign", 32'(it.exp_err), 32'd1);
        do_load(it, 0);
        it = model(32'h100, 3'b011, 0, 32'h1234_5678);
        chk("model_illegal", 32'(it.exp_err), 32'd3);
        do_load(it, 0);

        it = model(32'h200, 3'b010, 1000, 32'hDEAD_BEEF);
        chk("model_timeout_bus", 32'(it.exp_bus), 32'd4);
        do_load(it, 0);
        it = model(32'h200, 3'b010, 3, 32'hDEAD_BEEF);
        chk("model_ack_at_expiry", 32'(it.exp_err), 32'd0);
        do_load(it, 0);

        it = model(32'h300, 3'b010, 1, 32'hCAFE_F00D);
        do_load(it, 5);

        // Reset in the middle of a bus read: the load must vanish.
        it = model(32'h400, 3'b010, 1000, 32'h0);
        q.push_back(it);
        bus_if.req_addr = it.addr; bus_if.req_funct3 = it.f3; bus_if.req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("async_rst_mem_req", 32'(bus_if.mem_req), 32'd0);
        chk("async_rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        chk("async_rst_mem_addr", bus_if.mem_addr, 32'd0);
        chk("async_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        q.delete();
        stray_hi = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        stray_hi = 1'b0;
        chk("post_rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);

        it = model(32'h3, 3'b100, 0, 32'hAB00_0000);
        chk("model_lbu", it.exp_data, 32'h0000_00AB);
        do_load(it, 0);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] f3;
            if ($urandom_range(9) < 8) f3 = legal_f3[$urandom_range(4)];
            else f3 = 3'($urandom);
            it = model($urandom, f3, int'($urandom_range(5)), $urandom);
            do_load(it, int'($urandom_range(3)));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete (checks=%0d failures=%0d)", checks, failures);
        $fatal(1);
    end
endmodule
